// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver with first-word-fall-through receive FIFO
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   rx              serial line (asynchronous, idle high)
//   k               clocks per bit (>= 4)
//   nbits           data length: 00=5, 01=6, 10=7, 11=8
//   pen, even       parity enable; 1 = even, 0 = odd
//   stop2           1 selects two stop bits
//   rd              FIFO pop strobe
//   clr_ovf         clears the sticky overflow flag
//   rdata           head entry data, right-aligned, upper bits 0
//   rperr/rferr/rbrk head entry parity / framing / break flags
//   empty, full     FIFO status
//   count           number of stored entries
//   ovf             sticky overflow flag
//   busy            receiver not idle
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int KW    = 19
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx,
  input  logic [KW-1:0]            k,
  input  logic [1:0]               nbits,
  input  logic                     pen,
  input  logic                     even,
  input  logic                     stop2,
  input  logic                     rd,
  input  logic                     clr_ovf,
  output logic [7:0]               rdata,
  output logic                     rperr,
  output logic                     rferr,
  output logic                     rbrk,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2, BRKWAIT
  } state_t;

  state_t          state;
  logic            rx_s1, rx_s2, rx_prev;
  logic [1:0]      settle;
  logic [KW-1:0]   cnt, tgt, k_l;
  logic            tick, start_edge;
  logic [1:0]      nb_l;
  logic            pen_l, even_l, s2_l;
  logic [7:0]      sh;
  logic [2:0]      bidx;
  logic            par, perr_r, ferr_r, allz;
  logic            push;
  logic [10:0]     pword;

  logic [10:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     fcnt;
  logic            do_rd, do_wr, ovf_set;
  logic [10:0]     head;

  // Synchronizer plus edge history. settle masks the edge detector until the
  // reset-loaded ones have flushed, so a line held low through reset must
  // first go high before a start bit is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
      settle  <= 2'd0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      if (settle != 2'd3) settle <= settle + 2'd1;
    end
  end

  assign start_edge = (settle == 2'd3) & rx_prev & ~rx_s2;

  // START samples mid-bit at k/2; every later sample is one full bit on.
  always_comb begin
    tgt = (state == START) ? {1'b0, k_l[KW-1:1]} : k_l;
    tick = (cnt == tgt - KW'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      k_l    <= '0;
      nb_l   <= 2'd0;
      pen_l  <= 1'b0;
      even_l <= 1'b0;
      s2_l   <= 1'b0;
      sh     <= 8'h00;
      bidx   <= 3'd0;
      par    <= 1'b0;
      perr_r <= 1'b0;
      ferr_r <= 1'b0;
      allz   <= 1'b0;
      push   <= 1'b0;
      pword  <= 11'h000;
    end else begin
      push <= 1'b0;
      if (state != IDLE && state != BRKWAIT)
        cnt <= tick ? '0 : cnt + KW'(1);
      case (state)
        IDLE: begin
          if (start_edge) begin
            state  <= START;
            cnt    <= '0;
            k_l    <= k;
            nb_l   <= nbits;
            pen_l  <= pen;
            even_l <= even;
            s2_l   <= stop2;
            sh     <= 8'h00;
            bidx   <= 3'd0;
            par    <= 1'b0;
            perr_r <= 1'b0;
            ferr_r <= 1'b0;
            allz   <= 1'b1;
          end
        end
        START: begin
          if (tick) state <= rx_s2 ? IDLE : DATA;
        end
        DATA: begin
          if (tick) begin
            sh[bidx] <= rx_s2;
            par      <= par ^ rx_s2;
            if (rx_s2) allz <= 1'b0;
            if (bidx == 3'(nb_l) + 3'd4)
              state <= pen_l ? PARITY : STOP1;
            else
              bidx <= bidx + 3'd1;
          end
        end
        PARITY: begin
          if (tick) begin
            // Mismatch against XOR (even) or inverted XOR (odd).
            perr_r <= rx_s2 ^ par ^ ~even_l;
            if (rx_s2) allz <= 1'b0;
            state <= STOP1;
          end
        end
        STOP1: begin
          if (tick) begin
            if (allz && !rx_s2) begin
              push  <= 1'b1;
              pword <= {1'b1, 1'b1, 1'b0, 8'h00};
              state <= BRKWAIT;
            end else if (s2_l) begin
              ferr_r <= ~rx_s2;
              state  <= STOP2;
            end else begin
              push  <= 1'b1;
              pword <= {1'b0, ~rx_s2, perr_r, sh};
              state <= IDLE;
            end
          end
        end
        STOP2: begin
          if (tick) begin
            push  <= 1'b1;
            pword <= {1'b0, ferr_r | ~rx_s2, perr_r, sh};
            state <= IDLE;
          end
        end
        BRKWAIT: begin
          if (rx_s2) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  // FIFO: a pop on a full FIFO frees the slot the simultaneous push uses.
  assign empty   = (fcnt == '0);
  assign full    = (fcnt == (AW+1)'(DEPTH));
  assign do_rd   = rd & ~empty;
  assign do_wr   = push & (~full | do_rd);
  assign ovf_set = push & full & ~rd;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= pword;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   fcnt <= fcnt + (AW+1)'(1);
        2'b01:   fcnt <= fcnt - (AW+1)'(1);
        default: fcnt <= fcnt;
      endcase
      if (ovf_set)      ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

  assign head  = empty ? 11'h000 : mem[rd_ptr];
  assign rdata = head[7:0];
  assign rperr = head[8];
  assign rferr = head[9];
  assign rbrk  = head[10];
  assign count = fcnt;

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning the receive FIFO entry count; the value SHALL be a power of 2 and at least 2.
REQ-002 The block SHALL have parameter KW, default 19, meaning the bit-time divisor width.
REQ-003 The block SHALL have port clk, input, 1 bit: the clock.
REQ-004 The block SHALL have port rst, input, 1 bit: the reset, asynchronous, active-high.
REQ-005 The block SHALL have port rx, input, 1 bit: the serial line, asynchronous, idle high.
REQ-006 The block SHALL have port k, input, KW bits: clocks per bit; k >= 4 is required.
REQ-007 The block SHALL have port nbits, input, 2 bits: data length; 00=5, 01=6, 10=7, 11=8.
REQ-008 The block SHALL have port pen, input, 1 bit: parity enable.
REQ-009 The block SHALL have port even, input, 1 bit: 1 selects even parity, 0 selects odd parity.
REQ-010 The block SHALL have port stop2, input, 1 bit: 1 selects two stop bits.
REQ-011 The block SHALL have port rd, input, 1 bit: FIFO pop strobe.
REQ-012 The block SHALL have port clr_ovf, input, 1 bit: clears the sticky overflow flag.
REQ-013 The block SHALL have port rdata, output, 8 bits: data of the head entry, right-aligned, with unused upper bits 0.
REQ-014 The block SHALL have ports rperr, rferr and rbrk, outputs, 1 bit each: the parity, framing and break flags of the head entry.
REQ-015 The block SHALL have ports empty and full, outputs, 1 bit each: FIFO status.
REQ-016 The block SHALL have port count, output, log2(DEPTH)+1 bits: the number of stored entries.
REQ-017 The block SHALL have port ovf, output, 1 bit: sticky overflow flag.
REQ-018 The block SHALL have port busy, output, 1 bit: high when the receive state machine is not in IDLE.

Function
REQ-019 rx SHALL pass through a 2-flop synchronizer, and all receive logic SHALL use the synchronized value.
REQ-020 The receive state machine SHALL have the states IDLE, START, DATA, PARITY, STOP1, STOP2 and BRKWAIT.
REQ-021 In IDLE, a synchronized high-to-low transition on rx SHALL:
- move the machine to START;
- latch k, nbits, pen, even and stop2 for the whole frame;
- clear the bit-time counter.
REQ-022 In START, after k>>1 clocks, rx SHALL be sampled:
- rx == 0 -> DATA;
- rx == 1 -> IDLE (false start, no push).
REQ-023 Each later state SHALL sample rx after k clocks, with the counter reloading on every sample.
REQ-024 DATA SHALL shift in the latched nbits count of bits, LSB first, then move to:
- PARITY when pen == 1;
- STOP1 when pen == 0.
REQ-025 In PARITY, the sampled bit SHALL be compared with the generated parity: XOR of the data bits for even, inverted XOR for odd; perr = 1 on mismatch.
REQ-026 In STOP1, a sampled 0 SHALL set ferr; the machine SHALL then go to STOP2 if stop2 == 1, else to the push step.
REQ-027 In STOP2, a sampled 0 SHALL set ferr, after which the push step SHALL follow.
REQ-028 Break condition: every sampled bit from start through STOP1 is 0.
REQ-029 On a break, the pushed entry SHALL be data 0, rferr = 1, rbrk = 1, and the machine SHALL enter BRKWAIT instead of IDLE.
REQ-030 BRKWAIT SHALL remain until synchronized rx == 1, then go to IDLE.
REQ-031 The push step SHALL write {brk, ferr, perr, data} into the FIFO in the clock after the last stop sample, and the machine SHALL return to IDLE in that same clock.
REQ-032 STOP2 SHALL be skipped for a break frame.
REQ-033 A new start bit SHALL be detectable in the cycle after returning to IDLE.
REQ-034 The FIFO SHALL be first-word-fall-through: rdata, rperr, rferr and rbrk show the head entry whenever empty == 0.
REQ-035 rd while empty == 1 SHALL be ignored, with no pointer change and no error.
REQ-036 A push while full == 1 and rd == 0 SHALL discard the new entry and set ovf; the FIFO contents SHALL stay unchanged.
REQ-037 A push and rd in the same cycle while full == 1 SHALL both take effect: count unchanged, ovf not set.
REQ-038 A push and rd in the same cycle while empty == 1 SHALL perform only the push, so count becomes 1.
REQ-039 ovf SHALL remain 1 until clr_ovf; if clr_ovf and a new overflow occur in the same cycle, ovf SHALL be 1.
REQ-040 Pointers SHALL wrap modulo DEPTH.
REQ-041 full SHALL be 1 exactly when count == DEPTH, and empty SHALL be 1 exactly when count == 0.
REQ-042 Changes to k, nbits, pen, even or stop2 during a frame SHALL have no effect until the next start bit.

Reset
REQ-043 While rst is high, the block SHALL hold:
- state IDLE;
- counters and shift register 0;
- synchronizer flops 1;
- FIFO pointers 0, so count = 0, empty = 1, full = 0;
- ovf = 0 and busy = 0;
- rdata, rperr, rferr and rbrk = 0.
REQ-044 Assertion of rst mid-frame SHALL abandon the frame with no push.
REQ-045 After rst deasserts, the block SHALL wait for rx high before accepting a start bit.

Verification
REQ-046 Scenario 1, basic frame: k=16, 8N1, rx sends 0xA5 -> one entry, rdata=0xA5, rperr=rferr=rbrk=0, count=1.
REQ-047 Scenario 2, parity: 7E1 with 0x41 and a correct parity bit, then a second frame with the parity bit flipped -> rdata=0x41 for both; rperr=0 for the first entry and 1 for the second.
REQ-048 Scenario 3, two stop bits: 8N2 with the second stop bit 0 -> rferr=1 and data intact.
REQ-049 Scenario 4, glitch and break: a 3-clock low glitch -> busy returns low with count unchanged; rx low for 20 bit times -> one entry 0x00 with rbrk=1 and rferr=1, and no further entries until rx goes high.
REQ-050 Scenario 5, overflow: DEPTH+1 frames with no rd -> count=DEPTH, full=1, ovf=1, and the head is still the first byte.
REQ-051 Scenario 5, recovery: after pops, the bytes drain in order; clr_ovf then drives ovf to 0.
REQ-052 Scenario 6, simultaneous push/pop: rd coincides with the push while full=1 -> count stays DEPTH and ovf=0.
REQ-053 Scenario 6, reset: rst asserted mid-frame -> empty=1, and the next clean frame is received correctly.
